axi4_rd_arbiter: RTL
====================

// Module: axi4_rd_arbiter
// PURPOSE
//  Shares one AXI4 read port (AR+R) between NM upstream masters; one burst in flight at a time.
//  Round-robin grant per burst; grant held from AR acceptance until the final R beat (RLAST).
//  Sits between the master FSMs and the slave: slave-facing side on M_AXI_*, master-facing side on S_*.
// PARAMETERS
//  NM    2   number of upstream masters (>=1)
//  IDW   4   AXI ID width, passed through unchanged
// PORTS
//  ACLK           in   1       clock, all logic on rising edge
//  ARESET         in   1       asynchronous active-high reset
//  S_ARVALID      in   NM      per-master AR valid
//  S_ARREADY      out  NM      per-master AR ready (one-hot or zero)
//  S_ARADDR       in   NM*32   per-master address, master i at [32i+:32]
//  S_ARLEN        in   NM*8    per-master burst length
//  S_ARSIZE       in   NM*3    per-master beat size
//  S_ARBURST      in   NM*2    per-master burst type
//  S_ARID         in   NM*IDW  per-master ID
//  S_RDATA        out  32      R data, broadcast to all masters
//  S_RRESP        out  2       R response, broadcast
//  S_RID          out  IDW     R ID, broadcast
//  S_RLAST        out  1       R last, broadcast
//  S_RVALID       out  NM      R valid, only granted bit may be 1
//  S_RREADY       in   NM      per-master R ready
//  M_AXI_ARADDR   out  32      registered address to slave
//  M_AXI_ARLEN    out  8       registered burst length
//  M_AXI_ARSIZE   out  3       registered beat size
//  M_AXI_ARBURST  out  2       registered burst type
//  M_AXI_ARID     out  IDW     registered ID
//  M_AXI_ARVALID  out  1       AR valid to slave
//  M_AXI_ARREADY  in   1       AR ready from slave
//  M_AXI_RDATA/RRESP/RID/RLAST  in  32/2/IDW/1  R payload from slave
//  M_AXI_RVALID   in   1       R valid from slave
//  M_AXI_RREADY   out  1       R ready to slave
//  ERR_LAST       out  1       1-cycle pulse: RLAST position mismatches ARLEN
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, M_AXI_AR* payload 0, last_grant=NM-1 (master 0 wins first).
//  IDLE: if any S_ARVALID, g = first requester after last_grant (wrapping). S_ARREADY[g]=1 combinationally
//   that cycle; payload of g registered into M_AXI_AR*, M_AXI_ARVALID=1 next cycle -> ADDR. No request: stay.
//  ADDR: hold M_AXI_ARVALID and payload stable until M_AXI_ARREADY; on handshake ARVALID=0, beat_cnt=0 -> DATA.
//  DATA: S_RVALID[g]=M_AXI_RVALID, M_AXI_RREADY=S_RREADY[g]; other S_RVALID bits 0. R path is combinational.
//   Each handshake increments beat_cnt (8-bit). Handshake with RLAST: last_grant<=g -> IDLE.
//   ERR_LAST pulses on handshake where (RLAST xor beat_cnt==ARLEN); burst still ends only on RLAST.
//  S_ARREADY is 0 outside IDLE; new requests wait, no request is lost or reordered per master.
//  M_AXI_RREADY=0 in IDLE/ADDR (stray R beats not accepted).
//  Min latency: S_ARVALID cycle 0 -> M_AXI_ARVALID cycle 1; IDLE re-entry cycle after RLAST beat.
//  Back-to-back: RLAST handshake in cycle n, next grant in cycle n+1.
//  ARESET mid-burst: immediate return to reset values; in-flight burst abandoned.
//  NM=1: always grants master 0; arbitration logic degenerates.
// STRUCTURE
//  axi_arb_pkg (include): state localparams IDLE/ADDR/DATA, AXI BURST_INCR=2'b01, RESP_OKAY=2'b00.
//  Sub-module rr_arbiter: req[NM], last_grant index -> one-hot grant + index; purely combinational.
//  Top: FSM, grant/last_grant regs, AR payload regs, beat counter, R demux.
// TESTING
//  M0 ARADDR=0x4 LEN=0; slave returns 0x12345678 RLAST -> S_RVALID=2'b01, S_RDATA=0x12345678, ERR_LAST=0.
//  M0,M1 request continuously from reset, LEN=0 -> grant order 0,1,0,1; ARADDR follows same order.
//  M_AXI_ARREADY low 5 cycles -> ARVALID/ARADDR stable, S_ARREADY=0 throughout, M1 grant only after RLAST.
//  M1 LEN=3, RVALID gaps + S_RREADY[1] toggling -> 4 beats delivered in order, RREADY mirrors S_RREADY[1].
//  M0 LEN=3, slave RLAST on beat 2 -> ERR_LAST pulse on beat 2, return to IDLE next cycle.
//  ARESET asserted in DATA -> outputs 0 same cycle; after release, pending M0/M1 -> M0 granted first.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arbiter #(
   parameter int NM = 2,
   parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [LW-1:0] last_grant,
   output logic [NM-1:0] grant,
   output logic [LW-1:0] grant_idx,
   output logic          any_req
);

   logic [LW-1:0] cand_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand_idx  = '0;
      any_req   = |req;
      for (int i = 1; i <= NM; i++) begin
         cand_idx = LW'((int'(last_grant) + i) % NM);
         if (req[cand_idx] && (grant == '0)) begin
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// Shares one AXI4 read port between NM masters, one burst in flight,
// round-robin per burst with the grant held until the RLAST beat.
module axi4_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NM  = 2,
   parameter int IDW = 4
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [NM-1:0]     S_ARVALID,
   output logic [NM-1:0]     S_ARREADY,
   input  logic [NM*32-1:0]  S_ARADDR,
   input  logic [NM*8-1:0]   S_ARLEN,
   input  logic [NM*3-1:0]   S_ARSIZE,
   input  logic [NM*2-1:0]   S_ARBURST,
   input  logic [NM*IDW-1:0] S_ARID,
   output logic [31:0]       S_RDATA,
   output logic [1:0]        S_RRESP,
   output logic [IDW-1:0]    S_RID,
   output logic              S_RLAST,
   output logic [NM-1:0]     S_RVALID,
   input  logic [NM-1:0]     S_RREADY,
   output logic [31:0]       M_AXI_ARADDR,
   output logic [7:0]        M_AXI_ARLEN,
   output logic [2:0]        M_AXI_ARSIZE,
   output logic [1:0]        M_AXI_ARBURST,
   output logic [IDW-1:0]    M_AXI_ARID,
   output logic              M_AXI_ARVALID,
   input  logic              M_AXI_ARREADY,
   input  logic [31:0]       M_AXI_RDATA,
   input  logic [1:0]        M_AXI_RRESP,
   input  logic [IDW-1:0]    M_AXI_RID,
   input  logic              M_AXI_RLAST,
   input  logic              M_AXI_RVALID,
   output logic              M_AXI_RREADY,
   output logic              ERR_LAST
);

   localparam int LW = (NM > 1) ? $clog2(NM) : 1;

   state_e         state_q, state_d;
   logic [LW-1:0]  grant_q, grant_d;
   logic [LW-1:0]  last_grant_q, last_grant_d;
   logic           arvalid_q, arvalid_d;
   logic [31:0]    araddr_q, araddr_d;
   logic [7:0]     arlen_q, arlen_d;
   logic [2:0]     arsize_q, arsize_d;
   logic [1:0]     arburst_q, arburst_d;
   logic [IDW-1:0] arid_q, arid_d;
   logic [7:0]     beat_cnt_q, beat_cnt_d;

   logic [NM-1:0]  rr_grant;
   logic [LW-1:0]  rr_idx;
   logic           rr_any;
   logic [NM-1:0]  s_arready;
   logic [NM-1:0]  s_rvalid;
   logic           r_hs;
   logic           err_last;
   logic           in_data;

   rr_arbiter #(.NM(NM), .LW(LW)) u_rr (
      .req        (S_ARVALID),
      .last_grant (last_grant_q),
      .grant      (rr_grant),
      .grant_idx  (rr_idx),
      .any_req    (rr_any)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      arvalid_d    = arvalid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;
      arburst_d    = arburst_q;
      arid_d       = arid_q;
      beat_cnt_d   = beat_cnt_q;
      s_arready    = '0;
      s_rvalid     = '0;
      r_hs         = 1'b0;
      err_last     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               s_arready = rr_grant;
               grant_d   = rr_idx;
               arvalid_d = 1'b1;
               state_d   = ADDR;
               for (int m = 0; m < NM; m++) begin
                  if (rr_idx == LW'(m)) begin
                     araddr_d  = S_ARADDR[32*m +: 32];
                     arlen_d   = S_ARLEN[8*m +: 8];
                     arsize_d  = S_ARSIZE[3*m +: 3];
                     arburst_d = S_ARBURST[2*m +: 2];
                     arid_d    = S_ARID[IDW*m +: IDW];
                  end
               end
            end
         end
         ADDR: begin
            if (M_AXI_ARREADY) begin
               arvalid_d  = 1'b0;
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            s_rvalid[grant_q] = M_AXI_RVALID;
            r_hs = M_AXI_RVALID && S_RREADY[grant_q];
            if (r_hs) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // Length mismatch is flagged but only RLAST ends the burst.
               err_last   = M_AXI_RLAST ^ (beat_cnt_q == arlen_q);
               if (M_AXI_RLAST) begin
                  last_grant_d = grant_q;
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= LW'(NM - 1);
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arsize_q     <= '0;
         arburst_q    <= '0;
         arid_q       <= '0;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         arvalid_q    <= arvalid_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arsize_q     <= arsize_d;
         arburst_q    <= arburst_d;
         arid_q       <= arid_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   // R payload is zeroed outside DATA so reset leaves every output at 0.
   assign in_data       = (state_q == DATA);
   assign S_ARREADY     = ARESET ? '0 : s_arready;
   assign S_RVALID      = s_rvalid;
   assign S_RDATA       = in_data ? M_AXI_RDATA : '0;
   assign S_RRESP       = in_data ? M_AXI_RRESP : '0;
   assign S_RID         = in_data ? M_AXI_RID   : '0;
   assign S_RLAST       = in_data ? M_AXI_RLAST : 1'b0;
   assign M_AXI_RREADY  = in_data && S_RREADY[grant_q];
   assign ERR_LAST      = err_last;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARLEN   = arlen_q;
   assign M_AXI_ARSIZE  = arsize_q;
   assign M_AXI_ARBURST = arburst_q;
   assign M_AXI_ARID    = arid_q;

endmodule
